// File: rtl/ppu_req_responder_if.sv
// PPU request bus: EX-stage request/response plus the arithmetic core handshake.
// slave = responder side, master = EX stage and core side.
interface ppu_req_responder_if #(
  parameter int PPU_OP_WIDTH = 3
);
  logic                    ppu_valid_in;
  logic [31:0]             ppu_in1;
  logic [31:0]             ppu_in2;
  logic [PPU_OP_WIDTH-1:0] ppu_op;
  logic [31:0]             ppu_out;
  logic                    ppu_valid_o;
  logic                    ppu_busy_o;
  logic                    ppu_timeout_o;
  logic                    core_valid_o;
  logic [PPU_OP_WIDTH-1:0] core_op_o;
  logic [31:0]             core_a_o;
  logic [31:0]             core_b_o;
  logic                    core_valid_i;
  logic [31:0]             core_result_i;

  modport slave (
    input  ppu_valid_in, ppu_in1, ppu_in2, ppu_op,
    input  core_valid_i, core_result_i,
    output ppu_out, ppu_valid_o, ppu_busy_o,
    output ppu_timeout_o, core_valid_o,
    output core_op_o, core_a_o, core_b_o
  );

  modport master (
    output ppu_valid_in, ppu_in1, ppu_in2, ppu_op,
    output core_valid_i, core_result_i,
    input  ppu_out, ppu_valid_o, ppu_busy_o,
    input  ppu_timeout_o, core_valid_o,
    input  core_op_o, core_a_o, core_b_o
  );
endinterface

// File: rtl/ppu_req_responder.sv
// Responder for EX-stage posit32 requests: resolves NaR/zero cases locally,
// forwards the rest to the arithmetic core with a bounded wait.
module ppu_req_responder #(
  parameter int PPU_OP_WIDTH = 3,
  parameter int TIMEOUT      = 64,
  parameter bit SHORTCUT_EN  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  ppu_req_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NAR = 32'h8000_0000;
  localparam logic [PPU_OP_WIDTH-1:0] OP_ADD = PPU_OP_WIDTH'(0);
  localparam logic [PPU_OP_WIDTH-1:0] OP_SUB = PPU_OP_WIDTH'(1);
  localparam logic [PPU_OP_WIDTH-1:0] OP_MUL = PPU_OP_WIDTH'(2);
  localparam logic [PPU_OP_WIDTH-1:0] OP_DIV = PPU_OP_WIDTH'(3);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CORE_WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             res_q, res_d;
  logic                    to_q, to_d;
  logic                    cv_q, cv_d;
  logic [PPU_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             a_q, a_d;
  logic [31:0]             b_q, b_d;

  logic        hit;
  logic [31:0] sc_res;
  logic        a_nar, b_nar, a_z, b_z;

  assign a_nar = bus.ppu_in1 == NAR;
  assign b_nar = bus.ppu_in2 == NAR;
  assign a_z   = bus.ppu_in1 == 32'd0;
  assign b_z   = bus.ppu_in2 == 32'd0;

  // First matching rule wins; ops outside ADD..DIV never hit.
  always_comb begin
    hit    = 1'b0;
    sc_res = 32'd0;
    if (SHORTCUT_EN && bus.ppu_op <= OP_DIV) begin
      if (a_nar || b_nar) begin
        hit    = 1'b1;
        sc_res = NAR;
      end else if (bus.ppu_op == OP_DIV && b_z) begin
        hit    = 1'b1;
        sc_res = NAR;
      end else if (bus.ppu_op == OP_MUL && (a_z || b_z)) begin
        hit    = 1'b1;
        sc_res = 32'd0;
      end else if (bus.ppu_op == OP_DIV && a_z) begin
        hit    = 1'b1;
        sc_res = 32'd0;
      end else if (bus.ppu_op == OP_ADD && a_z) begin
        hit    = 1'b1;
        sc_res = bus.ppu_in2;
      end else if (bus.ppu_op == OP_ADD && b_z) begin
        hit    = 1'b1;
        sc_res = bus.ppu_in1;
      end else if (bus.ppu_op == OP_SUB && b_z) begin
        hit    = 1'b1;
        sc_res = bus.ppu_in1;
      end else if (bus.ppu_op == OP_SUB && a_z) begin
        hit    = 1'b1;
        sc_res = ~bus.ppu_in2 + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    to_d    = to_q;
    cv_d    = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ppu_valid_in) begin
          op_d = bus.ppu_op;
          a_d  = bus.ppu_in1;
          b_d  = bus.ppu_in2;
          if (hit) begin
            res_d   = sc_res;
            state_d = RESP;
          end else begin
            cnt_d   = '0;
            cv_d    = 1'b1;
            state_d = CORE_WAIT;
          end
        end
      end
      CORE_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done on the expiry cycle still wins over the timeout.
        if (bus.core_valid_i) begin
          res_d   = bus.core_result_i;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = NAR;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      cv_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      to_q    <= to_d;
      cv_q    <= cv_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.ppu_out       = res_q;
  assign bus.ppu_valid_o   = state_q == RESP;
  assign bus.ppu_busy_o    = state_q != IDLE;
  assign bus.ppu_timeout_o = to_q;
  assign bus.core_valid_o  = cv_q;
  assign bus.core_op_o     = op_q;
  assign bus.core_a_o      = a_q;
  assign bus.core_b_o      = b_q;
endmodule
